// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment decoder: pattern table,
// segment bit positions and the FIFO entry layout.
package seg7_pkg;

   typedef enum int {
      SEG_A = 0,
      SEG_B = 1,
      SEG_C = 2,
      SEG_D = 3,
      SEG_E = 4,
      SEG_F = 5,
      SEG_G = 6
   } seg_bit_e;

   localparam int SEG_W        = int'(SEG_G) - int'(SEG_A) + 1;
   localparam int NUM_PATTERNS = 16;

   // Active-low patterns, bit6..bit0 = g..a, indexed by the nibble they encode.
   localparam logic [SEG_W-1:0] SEG_TABLE [NUM_PATTERNS] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct packed {
      logic       err;
      logic [3:0] nibble;
   } fifo_entry_t;

endpackage

// File: rtl/seg7_lookup.sv
// Combinational pattern-to-nibble lookup; unknown patterns give nibble 0 with err set.
module seg7_lookup
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] pattern_i,
   output logic [3:0]       nibble_o,
   output logic             err_o
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      nibble_o = '0;
      err_o    = 1'b1;
      for (int i = 0; i < NUM_PATTERNS; i++) begin
         if (pattern_i == SEG_TABLE[i]) begin
            nibble_o = 4'(i);
            err_o    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_decoder.sv
// Seven-segment decoder: one registered decode stage feeding a DEPTH-entry FIFO.
// Define SEG7_ERRCNT_EN to add the saturating err_count output.
module seg7_decoder
   import seg7_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [SEG_W-1:0] seg_in,
   input  logic             seg_valid,
   output logic             seg_ready,
   output logic [3:0]       hex_out,
   output logic             hex_err,
   output logic             hex_valid,
   input  logic             hex_ready
`ifdef SEG7_ERRCNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [3:0]       lk_nibble;
   logic             lk_err;
   logic             accept;
   logic             push;
   logic             pop;
   logic             ready_en_q;
   logic             stage_valid_q, stage_valid_d;
   fifo_entry_t      stage_entry_q, stage_entry_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] occupancy;
   fifo_entry_t      mem_q [DEPTH];
   fifo_entry_t      head;

   seg7_lookup u_lookup (
      .pattern_i (seg_in),
      .nibble_o  (lk_nibble),
      .err_o     (lk_err)
   );

   // The stage counts toward occupancy so an accepted input always has a FIFO slot.
   assign occupancy = count_q + CNT_W'(stage_valid_q);
   assign seg_ready = ready_en_q && (occupancy != CNT_W'(DEPTH));
   assign accept    = seg_valid && seg_ready;
   assign push      = stage_valid_q;
   assign hex_valid = (count_q != '0);
   assign pop       = hex_valid && hex_ready;
   assign head      = mem_q[rd_ptr_q];
   assign hex_out   = hex_valid ? head.nibble : 4'h0;
   assign hex_err   = hex_valid && head.err;

   always_comb begin
      stage_valid_d = accept;
      stage_entry_d = stage_entry_q;
      if (accept) begin
         stage_entry_d = '{err: lk_err, nibble: lk_nibble};
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
         ready_en_q    <= 1'b0;
         stage_valid_q <= 1'b0;
         stage_entry_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         ready_en_q    <= 1'b1;
         stage_valid_q <= stage_valid_d;
         stage_entry_q <= stage_entry_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // NOTE: storage is not reset; outputs are gated by hex_valid so stale data never leaks.
   always_ff @(posedge Clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= stage_entry_q;
      end
   end

`ifdef SEG7_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && lk_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: vector table plus scoreboard queue,
// with hand-written sequences for backpressure, wrap, reset and saturation.
module tb_seg7_decoder;

   typedef struct packed {
      logic       err;
      logic [3:0] nib;
   } exp_t;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] nib;
      logic       err;
   } vec_t;

   logic       Clock     = 1'b0;
   logic       Resetn    = 1'b0;
   logic [6:0] seg_in    = '0;
   logic       seg_valid = 1'b0;
   logic       hex_ready = 1'b0;
   logic       seg_ready;
   logic [3:0] hex_out;
   logic       hex_err;
   logic       hex_valid;
`ifdef SEG7_ERRCNT_EN
   logic [7:0] err_count;
`endif

   seg7_decoder #(.DEPTH(4)) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .seg_in    (seg_in),
      .seg_valid (seg_valid),
      .seg_ready (seg_ready),
      .hex_out   (hex_out),
      .hex_err   (hex_err),
      .hex_valid (hex_valid),
      .hex_ready (hex_ready)
`ifdef SEG7_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 Clock = ~Clock;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t cur_exp;
   int   exp_errcnt = 0;
   logic last_acc = 1'b0;
   vec_t vecs[18];
   logic [6:0] table_pat [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; scores this cycle, then crosses one edge.
   task automatic step();
      logic acc;
      logic pop;
      acc = seg_valid && seg_ready;
      pop = hex_valid && hex_ready;
      if (hex_valid) begin
         if (q.size() == 0) begin
            check("spurious_valid", 32'(hex_valid), 32'd0);
         end else begin
            check("head_nibble", 32'(hex_out), 32'(q[0].nib));
            check("head_err", 32'(hex_err), 32'(q[0].err));
            if (pop) void'(q.pop_front());
         end
      end
      if (acc) begin
         q.push_back(cur_exp);
         if (cur_exp.err && exp_errcnt < 255) exp_errcnt++;
      end
      last_acc = acc;
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic send(input logic [6:0] s, input logic [3:0] n, input logic e);
      seg_in    = s;
      seg_valid = 1'b1;
      cur_exp   = '{err: e, nib: n};
      last_acc  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (last_acc) break;
      end
      check("accept_timeout", 32'(last_acc), 32'd1);
      seg_valid = 1'b0;
   endtask

   task automatic drain();
      hex_ready = 1'b1;
      seg_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (q.size() == 0 && !hex_valid) break;
         step();
      end
      check("drain_queue_empty", 32'(q.size()), 32'd0);
      check("drain_valid_low", 32'(hex_valid), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         vecs[i].seg = table_pat[i];
         vecs[i].nib = 4'(i);
         vecs[i].err = 1'b0;
      end
      vecs[16] = '{seg: 7'h7F, nib: 4'h0, err: 1'b1};
      vecs[17] = '{seg: 7'h55, nib: 4'h0, err: 1'b1};

      // Reset state
      #12;
      check("rst_seg_ready", 32'(seg_ready), 32'd0);
      check("rst_hex_valid", 32'(hex_valid), 32'd0);
      check("rst_hex_out", 32'(hex_out), 32'd0);
      check("rst_hex_err", 32'(hex_err), 32'd0);
      @(negedge Clock);
      Resetn = 1'b1;
      check("ready_before_first_edge", 32'(seg_ready), 32'd0);
      step();
      check("ready_after_release", 32'(seg_ready), 32'd1);

      // All 16 table patterns back-to-back, with first-output latency
      hex_ready = 1'b1;
      send(vecs[0].seg, vecs[0].nib, vecs[0].err);
      check("latency_after_accept_edge", 32'(hex_valid), 32'd0);
      send(vecs[1].seg, vecs[1].nib, vecs[1].err);
      check("latency_second_edge", 32'(hex_valid), 32'd1);
      for (int i = 2; i < 16; i++) send(vecs[i].seg, vecs[i].nib, vecs[i].err);
      drain();

      // Undecodable patterns
      for (int i = 16; i < 18; i++) send(vecs[i].seg, vecs[i].nib, vecs[i].err);
      drain();
`ifdef SEG7_ERRCNT_EN
      check("err_count_two", 32'(err_count), 32'(exp_errcnt));
`endif

      // Pop while empty is ignored
      hex_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("empty_valid", 32'(hex_valid), 32'd0);
         check("empty_out", 32'(hex_out), 32'd0);
      end
      send(7'h24, 4'h2, 1'b0);
      drain();

      // Backpressure: 4 accepts fill DEPTH=4, the 5th waits
      hex_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(vecs[i + 4].seg, vecs[i + 4].nib, vecs[i + 4].err);
      check("full_ready_low", 32'(seg_ready), 32'd0);
      seg_in    = vecs[8].seg;
      seg_valid = 1'b1;
      cur_exp   = '{err: vecs[8].err, nib: vecs[8].nib};
      for (int k = 0; k < 3; k++) begin
         step();
         check("full_hold_ready", 32'(seg_ready), 32'd0);
         check("full_hold_valid", 32'(hex_valid), 32'd1);
      end
      check("fifth_not_accepted", 32'(q.size()), 32'd4);
      hex_ready = 1'b1;
      send(vecs[8].seg, vecs[8].nib, vecs[8].err);
      drain();

      // Full FIFO then continuous push and pop across pointer wrap
      hex_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(vecs[i + 2].seg, vecs[i + 2].nib, vecs[i + 2].err);
      step();
      check("wrap_full_ready", 32'(seg_ready), 32'd0);
      hex_ready = 1'b1;
      seg_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         seg_in  = vecs[(6 + i) % 16].seg;
         cur_exp = '{err: 1'b0, nib: vecs[(6 + i) % 16].nib};
         if (i >= 2) begin
            check("steady_ready", 32'(seg_ready), 32'd1);
            check("steady_valid", 32'(hex_valid), 32'd1);
         end
         step();
      end
      seg_valid = 1'b0;
      drain();

      // Asynchronous reset with entries queued
      hex_ready = 1'b0;
      send(7'h40, 4'h0, 1'b0);
      send(7'h7F, 4'h0, 1'b1);
      send(7'h79, 4'h1, 1'b0);
      step();
      step();
      check("queued_valid", 32'(hex_valid), 32'd1);
      #2;
      Resetn = 1'b0;
      #1;
      check("midrst_valid", 32'(hex_valid), 32'd0);
      check("midrst_out", 32'(hex_out), 32'd0);
      check("midrst_err", 32'(hex_err), 32'd0);
      check("midrst_ready", 32'(seg_ready), 32'd0);
`ifdef SEG7_ERRCNT_EN
      check("midrst_err_count", 32'(err_count), 32'd0);
`endif
      q.delete();
      exp_errcnt = 0;
      @(negedge Clock);
      Resetn = 1'b1;
      step();
      check("postrst_ready", 32'(seg_ready), 32'd1);
      hex_ready = 1'b1;
      send(7'h30, 4'h3, 1'b0);
      drain();

      // Saturation of the error counter
      hex_ready = 1'b1;
      for (int i = 0; i < 300; i++) send(7'h7F, 4'h0, 1'b1);
      drain();
`ifdef SEG7_ERRCNT_EN
      check("err_count_saturated", 32'(err_count), 32'(exp_errcnt));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning output FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port Clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port seg_in  input  7  active-low segment pattern: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 SHALL have port seg_valid  input  1  seg_in is valid this cycle.
REQ-006 SHALL have port seg_ready  output  1  block accepts seg_in this cycle.
REQ-007 SHALL have port hex_out  output  4  decoded nibble at FIFO head.
REQ-008 SHALL have port hex_err  output  1  head entry came from a pattern not in the table.
REQ-009 SHALL have port hex_valid  output  1  FIFO head is valid.
REQ-010 SHALL have port hex_ready  input  1  consumer takes the head this cycle.
REQ-011 SHALL have port err_count  output  8  saturating count of undecodable patterns (present only with SEG7_ERRCNT_EN).

Function
REQ-012 SHALL decode active-low patterns, hex g..a: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-013 SHALL, for any other pattern, emit hex_out=0 with hex_err=1.
REQ-014 SHALL accept an input on every rising edge where seg_valid and seg_ready are both 1; no other edge accepts input.
REQ-015 SHALL register the decode result in one stage; the FIFO write occurs one edge after acceptance; earliest hex_valid is two edges after acceptance.
REQ-016 SHALL drive seg_ready = 0 when (FIFO occupancy + stage-valid) equals DEPTH, else 1; it is a registered or occupancy-only signal and SHALL NOT depend combinationally on hex_ready.
REQ-017 SHALL pop the head on every edge where hex_valid and hex_ready are both 1.
REQ-018 SHALL hold hex_out/hex_err stable while hex_valid=1 and hex_ready=0.
REQ-019 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve order.
REQ-020 SHALL drive hex_valid=0 when empty; a pop request while empty SHALL be ignored.
REQ-021 SHALL wrap read/write pointers modulo DEPTH with no loss or duplication.
REQ-022 SHALL never drop an accepted input; input order equals output order.

Reset
REQ-023 SHALL, on Resetn=0 at any time (including mid-transfer), clear immediately: stage-valid=0, occupancy=0, pointers=0, hex_valid=0, hex_out=0, hex_err=0, err_count=0.
REQ-024 SHALL drive seg_ready=0 while Resetn=0 and 1 on the first edge after release.

Configuration
REQ-025 SHALL, with macro SEG7_ERRCNT_EN defined, include err_count: +1 per accepted undecodable pattern, saturating at 255.
REQ-026 SHALL, without SEG7_ERRCNT_EN, omit the err_count port and counter logic; all other behaviour is unchanged.

Structure
REQ-027 SHALL place the 16-entry pattern table constants, the segment bit-index constants, and the FIFO entry typedef {err, nibble} in shared package seg7_pkg.
REQ-028 SHALL implement decoding in combinational sub-module seg7_lookup (7-bit pattern in; 4-bit nibble and err out).

Verification
REQ-029 SHALL cover: all 16 table patterns back-to-back with hex_ready=1 -> nibbles 0..F in order, hex_err=0, first hex_valid 2 edges after first accept.
REQ-030 SHALL cover: seg_in=7F (blank) and 7'h55 -> hex_out=0, hex_err=1, err_count=2 (macro on).
REQ-031 SHALL cover: hex_ready=0, push 5 patterns with DEPTH=4 -> seg_ready=0 after 4 accepts; release hex_ready -> 4 entries out in order, then the 5th accepted.
REQ-032 SHALL cover: full FIFO with simultaneous push and pop for 10 cycles -> occupancy constant, order preserved across pointer wrap.
REQ-033 SHALL cover: Resetn asserted with 3 entries queued -> hex_valid=0 and err_count=0 immediately; after release, first new pattern 30 -> hex_out=3.
REQ-034 SHALL cover: 300 invalid patterns -> err_count holds at 255.
